fpipe_shell: RTL
================

# fpipe_shell

Handshake front-end for the fixed-latency, no-handshake float pipelines (fsub and its siblings).
- Accepts operand pairs over valid/ready and drives them into an attached unit.
- Tracks in-flight operations with a valid shift register and captures results in a result FIFO.
- Returns results in order over valid/ready, so upstream logic can apply backpressure the raw pipeline cannot.
- Sits between the instruction issue logic and each FP arithmetic unit.

## Interface
Parameters:
- LATENCY, 2: register edges from the unit sampling its inputs to its output being valid; equals the unit's pipeline depth.
- DEPTH, 8: result FIFO entries and total outstanding-operation credit. Power of two, ≥ LATENCY+3.
- TAG_W, 4: tag width; used only with FPIPE_TAG_EN.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  operand pair offered.
- req_ready  out  1  shell can accept.
- req_x1, req_x2  in  32  IEEE-754 single operands.
- req_tag  in  TAG_W  request tag (FPIPE_TAG_EN only).
- u_x1, u_x2  out  32  registered operands to the unit.
- u_y  in  32  unit result.
- rsp_valid  out  1  result available at FIFO head.
- rsp_ready  in  1  consumer takes result.
- rsp_y  out  32  result.
- rsp_tag  out  TAG_W  tag of the result (FPIPE_TAG_EN only).
- busy  out  1  any operation in flight or buffered.

## Operation
- Accept occurs on a rising edge with req_valid && req_ready.
  - On accept edge T: u_x1/u_x2 <= req_x1/req_x2; v[0] <= 1. Otherwise v[0] <= 0 and u_x1/u_x2 hold their value.
- Valid pipe v[0..LATENCY] shifts every edge, tracking the operation through the unit.
  - v[LATENCY]=1 marks the cycle in which u_y holds that operation's result.
  - When v[LATENCY]=1, the next edge pushes u_y into the FIFO.
- reserved = popcount(v[0..LATENCY]) + fifo_count.
- req_ready = !rst && (reserved < DEPTH). It is a function of registers only; there is no combinational path from rsp_ready or req_valid.
- FIFO is show-ahead with registered storage:
  - rsp_valid = !empty; rsp_y/rsp_tag come from the head entry.
  - Pop on rsp_valid && rsp_ready.
- Push and pop on the same edge are always legal, including when the FIFO is full. Count is unchanged and data stays in order.
- Credit guarantees that a push never finds the FIFO full without a simultaneous pop. Overflow is impossible by construction and is an assertion target.
- Results leave in acceptance order; no reordering, no dropping.
- busy = |v || !empty.
- Inputs have no arithmetic role. All 32-bit data passes through bit-exact.

## Timing
- Reset values:
  - v = 0, FIFO empty (pointers 0), u_x1 = u_x2 = 0.
  - rsp_valid = 0, rsp_y = 0, rsp_tag = 0, busy = 0, req_ready = 0 while rst is high.
- Accept to rsp_valid: accept at edge T gives rsp_valid high from edge T+LATENCY+1. This is 3 cycles for LATENCY=2.
- Throughput is one operation per cycle while rsp_ready=1. This requires DEPTH ≥ LATENCY+3, because in steady state reserved = LATENCY+2.
- With rsp_ready=0, exactly DEPTH operations are accepted, then req_ready drops.
  - req_ready returns on the edge after the first pop.
- Reset mid-operation: all in-flight and buffered results are discarded.
  - The unit itself has no reset; its outputs are ignored because v=0.
  - No rsp_valid is raised for pre-reset requests.

## Configuration
- FPIPE_TAG_EN defined:
  - req_tag/rsp_tag ports exist.
  - A tag shift register parallels v, and tags are stored with results in the FIFO.
  - rsp_tag always matches the tag of the request producing rsp_y.
- Undefined: tag ports and all tag storage are absent; behaviour is otherwise identical.

## Structure
- Package fpipe_pkg holds:
  - FLOAT_W = 32.
  - typedef float_t (logic [31:0]).
  - Default LATENCY and DEPTH constants shared with unit wrappers.
- Sub-module fpipe_fifo: parameterized synchronous show-ahead FIFO with width and depth parameters, count output, and simultaneous push/pop.
- The valid/tag pipe and credit logic live in fpipe_shell.

## Test plan
- Single op:
  - Stimulus: unit = fsub, x1=0x40400000 (3.0), x2=0x3F800000 (1.0), rsp_ready=1.
  - Response: rsp_valid exactly 3 cycles after accept, rsp_y=0x40000000; busy drops the cycle after pop.
- Streaming:
  - Stimulus: 16 back-to-back requests with x1=i·1.0, x2=0, rsp_ready=1.
  - Response: req_ready never drops; 16 responses in order, one per cycle.
- Backpressure:
  - Stimulus: rsp_ready=0, continuous req_valid.
  - Response: exactly 8 accepts, then req_ready=0. On release, 8 results come out in order, and req_ready reasserts one edge after the first pop.
- Full with simultaneous push/pop:
  - Stimulus: FIFO at 7 entries with an op at v[LATENCY], rsp_ready=1.
  - Response: count stays 7, order preserved, no overflow assertion.
- Reset mid-flight:
  - Stimulus: accept 2 ops, assert rst the following cycle for 1 cycle.
  - Response: no rsp_valid for them, busy=0, u_x1=u_x2=0; req_ready=1 the cycle after rst deasserts.
- With FPIPE_TAG_EN:
  - Stimulus: tags 0..7 issued under random rsp_ready.
  - Response: rsp_tag sequence is 0..7, each paired with its own rsp_y.

Source files
------------

// File: rtl/fpipe_pkg.sv
// Shared types and default geometry for the float pipeline shells and unit wrappers.
// FPIPE_TAG_EN (optional) adds a request tag carried alongside each result.
package fpipe_pkg;

   localparam int FLOAT_W       = 32;
   localparam int FPIPE_LATENCY = 2;
   localparam int FPIPE_DEPTH   = 8;

   typedef logic [FLOAT_W-1:0] float_t;

   // Width of an occupancy counter that must hold 0..depth inclusive.
   function automatic int fpipe_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/fpipe_fifo.sv
// Synchronous show-ahead FIFO with registered storage, occupancy count and
// simultaneous push/pop (legal even when full). Head data reads as zero while empty.
module fpipe_fifo
   import fpipe_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          push,
   input  logic [WIDTH-1:0]              push_data,
   input  logic                          pop,
   output logic [WIDTH-1:0]              pop_data,
   output logic                          empty,
   output logic                          full,
   output logic [fpipe_cnt_w(DEPTH)-1:0] count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = fpipe_cnt_w(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [CW-1:0]    cnt;
   logic             do_push;
   logic             do_pop;

   assign empty    = (cnt == '0);
   assign full     = (cnt == CW'(DEPTH));
   assign count    = cnt;
   assign do_pop   = pop && !empty;
   // A push into a full FIFO is only taken when the head leaves on the same edge.
   assign do_push  = push && (!full || do_pop);
   assign pop_data = empty ? '0 : mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         cnt <= cnt + CW'(do_push) - CW'(do_pop);
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   a_no_overflow: assert property (@(posedge clk) disable iff (rst)
      !(push && full && !pop));

endmodule

// File: rtl/fpipe_shell.sv
// Valid/ready front-end for fixed-latency, no-handshake float units: credit-limited
// issue, in-flight valid pipe and in-order result FIFO. FPIPE_TAG_EN adds req_tag/rsp_tag.
module fpipe_shell
   import fpipe_pkg::*;
#(
   parameter int LATENCY = FPIPE_LATENCY,
   parameter int DEPTH   = FPIPE_DEPTH,
   parameter int TAG_W   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  float_t           req_x1,
   input  float_t           req_x2,
`ifdef FPIPE_TAG_EN
   input  logic [TAG_W-1:0] req_tag,
`endif
   output float_t           u_x1,
   output float_t           u_x2,
   input  float_t           u_y,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output float_t           rsp_y,
`ifdef FPIPE_TAG_EN
   output logic [TAG_W-1:0] rsp_tag,
`endif
   output logic             busy
);

   // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
   // waits for ready, and req_ready depends only on registered state (plus rst).

   localparam int CW    = fpipe_cnt_w(DEPTH);
   localparam int RES_W = $clog2(DEPTH + LATENCY + 1) + 1;
`ifdef FPIPE_TAG_EN
   localparam int ENTRY_W = FLOAT_W + TAG_W;
`else
   // TAG_W stays in the parameter list so both builds share one instantiation.
   localparam int ENTRY_W = FLOAT_W + 0 * TAG_W;
`endif

   logic [LATENCY:0]   v;
   logic               accept;
   logic [RES_W-1:0]   reserved;
   logic [CW-1:0]      fifo_count;
   logic               fifo_empty;
   logic               fifo_full;
   logic [ENTRY_W-1:0] push_entry;
   logic [ENTRY_W-1:0] head_entry;

   assign accept = req_valid && req_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         v    <= '0;
         u_x1 <= '0;
         u_x2 <= '0;
      end else begin
         v <= {v[LATENCY-1:0], accept};
         if (accept) begin
            u_x1 <= req_x1;
            u_x2 <= req_x2;
         end
      end
   end

   // Credit covers everything in the unit plus everything buffered, so a result
   // can never arrive at a full FIFO unless the head leaves on the same edge.
   always_comb begin
      reserved = RES_W'(fifo_count);
      for (int i = 0; i <= LATENCY; i++) begin
         reserved = reserved + RES_W'(v[i]);
      end
   end

   assign req_ready = !rst && (reserved < RES_W'(DEPTH));

`ifdef FPIPE_TAG_EN
   logic [TAG_W-1:0] tag_p [LATENCY+1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i <= LATENCY; i++) tag_p[i] <= '0;
      end else begin
         tag_p[0] <= req_tag;
         for (int i = 1; i <= LATENCY; i++) tag_p[i] <= tag_p[i-1];
      end
   end

   assign push_entry = {tag_p[LATENCY], u_y};
   assign rsp_tag    = head_entry[ENTRY_W-1:FLOAT_W];
`else
   assign push_entry = u_y;
`endif

   fpipe_fifo #(
      .WIDTH (ENTRY_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (v[LATENCY]),
      .push_data (push_entry),
      .pop       (rsp_ready),
      .pop_data  (head_entry),
      .empty     (fifo_empty),
      .full      (fifo_full),
      .count     (fifo_count)
   );

   assign rsp_valid = !fifo_empty;
   assign rsp_y     = head_entry[FLOAT_W-1:0];
   assign busy      = (|v) || !fifo_empty;

   a_credit: assert property (@(posedge clk) disable iff (rst)
      !(v[LATENCY] && fifo_full && !rsp_ready));

endmodule
